// File: rtl/fp_mul_pkg.sv
// Shared definitions for the FP32 multiplier datapath (unpack, multiply, normalize/round).
package fp_mul_pkg;

  // Exponent sum is carried as 10-bit two's complement so ea+eb-127 never wraps.
  localparam int unsigned EXP_W    = 10;
  localparam int          EXP_BIAS = 127;
  localparam int          EXP_INF  = 2 * EXP_BIAS + 1;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef logic signed [EXP_W-1:0] exp_t;

  typedef enum logic [2:0] {
    StIdle,
    StNorm,
    StRound,
    StRenorm,
    StPack
  } state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a normalized mantissa; reports carry-out.
module fp_round_rne #(
  parameter int unsigned MW = 24
) (
  input  logic [MW-1:0] mant_i,
  input  logic          guard_i,
  input  logic          sticky_i,
  output logic [MW-1:0] mant_o,
  output logic          carry_o
);

  logic          inc;
  logic [MW:0]   sum;

  // Round up above half, or exactly at half when the LSB is odd.
  always_comb begin
    inc     = guard_i & (sticky_i | mant_i[0]);
    sum     = {1'b0, mant_i} + {{MW{1'b0}}, inc};
    mant_o  = sum[MW-1:0];
    carry_o = sum[MW];
  end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Normalize, round (RNE), range-check and pack the 48-bit mantissa product into FP32.
module fp_mul_norm_round
  import fp_mul_pkg::*;
#(
  parameter int unsigned MW = 24,
  parameter int unsigned EW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                startNorm,
  input  logic                signIn,
  input  exp_t                expIn,
  input  logic [2*MW-1:0]     prodIn,
  input  logic                zeroIn,
  input  logic                infIn,
  input  logic                nanIn,
  output logic [EW+MW-1:0]    result,
  output logic                doneNorm,
  output logic                overflow,
  output logic                underflow
);

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  exp_t                exp_q, exp_d;
  logic [2*MW-1:0]     prod_q, prod_d;
  logic                zero_q, zero_d;
  logic                inf_q, inf_d;
  logic                nan_q, nan_d;
  logic [MW-1:0]       mant_q, mant_d;
  logic                guard_q, guard_d;
  logic                sticky_q, sticky_d;
  logic [EW+MW-1:0]    result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic [MW-1:0]       rnd_mant;
  logic                rnd_carry;

  fp_round_rne #(
    .MW (MW)
  ) u_round (
    .mant_i   (mant_q),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .mant_o   (rnd_mant),
    .carry_o  (rnd_carry)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      prod_q   <= '0;
      zero_q   <= 1'b0;
      inf_q    <= 1'b0;
      nan_q    <= 1'b0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      prod_q   <= prod_d;
      zero_q   <= zero_d;
      inf_q    <= inf_d;
      nan_q    <= nan_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Next-state and datapath updates for each FSM step.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    prod_d   = prod_q;
    zero_d   = zero_q;
    inf_d    = inf_q;
    nan_d    = nan_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    unique case (state_q)
      StIdle: begin
        if (startNorm) begin
          sign_d  = signIn;
          exp_d   = expIn;
          prod_d  = prodIn;
          zero_d  = zeroIn;
          inf_d   = infIn;
          nan_d   = nanIn;
          state_d = StNorm;
        end
      end

      StNorm: begin
        // Normal operands give a product in [1,4): at most one shift needed.
        if (prod_q[2*MW-1]) begin
          exp_d    = exp_q + exp_t'(1);
          mant_d   = prod_q[2*MW-1:MW];
          guard_d  = prod_q[MW-1];
          sticky_d = |prod_q[MW-2:0];
        end else begin
          mant_d   = prod_q[2*MW-2:MW-1];
          guard_d  = prod_q[MW-2];
          sticky_d = |prod_q[MW-3:0];
        end
        state_d = StRound;
      end

      StRound: begin
        mant_d  = rnd_mant;
        state_d = rnd_carry ? StRenorm : StPack;
      end

      StRenorm: begin
        // Carry out of all-ones mantissa: value is exactly 2.0 * 2^exp.
        mant_d  = {1'b1, {(MW-1){1'b0}}};
        exp_d   = exp_q + exp_t'(1);
        state_d = StPack;
      end

      StPack: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (nan_q || (inf_q && zero_q)) begin
          result_d = QNAN;
        end else if (inf_q) begin
          result_d = {sign_q, {EW{1'b1}}, {(MW-1){1'b0}}};
        end else if (zero_q) begin
          result_d = {sign_q, {(EW+MW-1){1'b0}}};
        end else if (exp_q >= exp_t'(EXP_INF)) begin
          result_d = {sign_q, {EW{1'b1}}, {(MW-1){1'b0}}};
          ovf_d    = 1'b1;
        end else if (exp_q <= exp_t'(0)) begin
          // Flush to zero; subnormal results are not produced.
          result_d = {sign_q, {(EW+MW-1){1'b0}}};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_q[EW-1:0], mant_q[MW-2:0]};
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign doneNorm  = (state_q == StIdle);

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed self-checking bench for fp_mul_norm_round.
module tb_fp_mul_norm_round;

  logic               clk;
  logic               rst;
  logic               startNorm;
  logic               signIn;
  logic signed [9:0]  expIn;
  logic [47:0]        prodIn;
  logic               zeroIn;
  logic               infIn;
  logic               nanIn;
  logic [31:0]        result;
  logic               doneNorm;
  logic               overflow;
  logic               underflow;

  int n_checks = 0;
  int n_errors = 0;

  fp_mul_norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .startNorm (startNorm),
    .signIn    (signIn),
    .expIn     (expIn),
    .prodIn    (prodIn),
    .zeroIn    (zeroIn),
    .infIn     (infIn),
    .nanIn     (nanIn),
    .result    (result),
    .doneNorm  (doneNorm),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    string             name;
    logic              sgn;
    logic signed [9:0] e;
    logic [47:0]       p;
    logic              z;
    logic              i;
    logic              n;
    logic [31:0]       res;
    logic              ovf;
    logic              unf;
    int                lat;
  } vec_t;

  vec_t vecs[12];

  task automatic set_inputs(input vec_t v);
    signIn = v.sgn;
    expIn  = v.e;
    prodIn = v.p;
    zeroIn = v.z;
    infIn  = v.i;
    nanIn  = v.n;
  endtask

  // Start one op from IDLE; lat counts edges from capture (1) until doneNorm returns.
  task automatic run_op(input vec_t v, output int lat);
    @(negedge clk);
    set_inputs(v);
    startNorm = 1'b1;
    @(posedge clk);
    #1;
    startNorm = 1'b0;
    lat = 1;
    while (!doneNorm && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int edges;
    vec_t a;
    vec_t b;

    vecs[0]  = '{"mul1p5",   1'b0, 10'sd127, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0, 4};
    vecs[1]  = '{"tie_even", 1'b0, 10'sd127, 48'h400000400000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 4};
    vecs[2]  = '{"tie_odd",  1'b0, 10'sd127, 48'h400000C00000, 1'b0, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0, 4};
    vecs[3]  = '{"rnd_carry",1'b0, 10'sd127, 48'h7FFFFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 5};
    vecs[4]  = '{"overflow", 1'b0, 10'sd254, 48'h800000000000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 4};
    vecs[5]  = '{"max_exp",  1'b0, 10'sd253, 48'h800000000000, 1'b0, 1'b0, 1'b0, 32'h7F000000, 1'b0, 1'b0, 4};
    vecs[6]  = '{"underflow",1'b1, 10'sd0,   48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 4};
    vecs[7]  = '{"min_exp",  1'b0, 10'sd1,   48'h400000000000, 1'b0, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b0, 4};
    vecs[8]  = '{"inf_zero", 1'b1, 10'sd127, 48'h400000000000, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 4};
    vecs[9]  = '{"inf_neg",  1'b1, 10'sd127, 48'h400000000000, 1'b0, 1'b1, 1'b0, 32'hFF800000, 1'b0, 1'b0, 4};
    vecs[10] = '{"zero_pos", 1'b0, 10'sd127, 48'h000000000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 4};
    vecs[11] = '{"nan",      1'b0, 10'sd127, 48'h400000000000, 1'b0, 1'b0, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 4};

    rst       = 1'b1;
    startNorm = 1'b0;
    set_inputs(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_done",   {31'b0, doneNorm},  32'd1);
    check_eq("reset_result", result,             32'h0);
    check_eq("reset_ovf",    {31'b0, overflow},  32'd0);
    check_eq("reset_unf",    {31'b0, underflow}, 32'd0);

    foreach (vecs[k]) begin
      run_op(vecs[k], lat);
      check_eq({vecs[k].name, "_res"}, result,             vecs[k].res);
      check_eq({vecs[k].name, "_ovf"}, {31'b0, overflow},  {31'b0, vecs[k].ovf});
      check_eq({vecs[k].name, "_unf"}, {31'b0, underflow}, {31'b0, vecs[k].unf});
      check_eq({vecs[k].name, "_lat"}, lat,                vecs[k].lat);
    end

    // startNorm pulsed during NORM must not disturb the running op or start another.
    a = vecs[0];
    b = vecs[4];
    @(negedge clk);
    set_inputs(a);
    startNorm = 1'b1;
    @(posedge clk);
    #1;
    startNorm = 1'b1;
    set_inputs(b);
    @(posedge clk);
    #1;
    startNorm = 1'b0;
    lat = 2;
    while (!doneNorm && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("ign_start_lat", lat, 32'd4);
    check_eq("ign_start_res", result, 32'h40100000);
    check_eq("ign_start_ovf", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("ign_start_idle", {31'b0, doneNorm}, 32'd1);

    // Reset while in ROUND aborts; the op must never reach PACK.
    @(negedge clk);
    set_inputs(vecs[4]);
    startNorm = 1'b1;
    @(posedge clk);
    #1;
    startNorm = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_round_done", {31'b0, doneNorm},  32'd1);
    check_eq("rst_round_res",  result,             32'h0);
    check_eq("rst_round_ovf",  {31'b0, overflow},  32'd0);
    check_eq("rst_round_unf",  {31'b0, underflow}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_round_hold", result, 32'h0);

    // Back-to-back with startNorm held high: PACK edges at 4 and 8 after the first capture.
    a = vecs[0];
    b = vecs[2];
    b.sgn = 1'b1;
    @(negedge clk);
    set_inputs(a);
    startNorm = 1'b1;
    edges = 0;
    while (edges < 8) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) set_inputs(b);
      if (edges == 5) startNorm = 1'b0;
      if (edges == 4) begin
        check_eq("b2b_first_done", {31'b0, doneNorm}, 32'd1);
        check_eq("b2b_first_res",  result,            32'h40100000);
      end
      if (edges == 5) check_eq("b2b_second_busy", {31'b0, doneNorm}, 32'd0);
    end
    check_eq("b2b_second_done", {31'b0, doneNorm}, 32'd1);
    check_eq("b2b_second_res",  result,            32'hBF800002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_mul_norm_round.md
Name: fp_mul_norm_round

Overview:
Downstream stage of the sequential 24x24 mantissa multiplier in the FP32 multiplier datapath. Consumes the 48-bit mantissa product, the pre-computed product sign and the biased exponent sum. Normalizes, rounds to nearest-even, detects overflow and underflow, and packs an IEEE-754 single-precision result. Multi-cycle FSM with start/done handshake, matching the multiplier's startMul/doneMul style.

Parameters:
MW, 24, mantissa width including hidden bit; product width is 2*MW.
EW, 8, stored exponent width; exponent bias is 2^(EW-1)-1 = 127.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
startNorm  in  1  start request; sampled only in IDLE
signIn  in  1  product sign (sa^sb)
expIn  in  10  signed two's-complement ea+eb-127; range -125..381
prodIn  in  48  unsigned mantissa product {1.xxx}*{1.xxx}
zeroIn  in  1  an operand is zero (FTZ upstream)
infIn  in  1  an operand is infinity
nanIn  in  1  an operand is NaN
result  out  32  packed FP32 result
doneNorm  out  1  high in IDLE; low while busy
overflow  out  1  result saturated to infinity
underflow  out  1  result flushed to zero

Behaviour:
- Reset (synchronous, rst=1 at edge): FSM -> IDLE; result=0, overflow=0, underflow=0. doneNorm=1 because the FSM is in IDLE. rst during any state aborts the operation, and nothing is written.
- States: IDLE -> NORM -> ROUND -> (RENORM) -> PACK -> IDLE.
- IDLE: doneNorm=1. On startNorm=1, capture all inputs into internal registers and go to NORM. startNorm in any other state is ignored.
- NORM:
  - If p[47]=1: exp=e+1; hidden=p[47]; frac=p[46:24]; guard=p[23]; sticky=|p[22:0].
  - Else: exp=e; hidden=p[46]; frac=p[45:23]; guard=p[22]; sticky=|p[21:0].
  - Upstream inputs are normals only, so a single-position normalization always suffices.
- ROUND (RNE): increment {hidden,frac} iff guard & (sticky | frac[0]). Compute the sum in 25 bits.
  - If the carry-out bit is set, go to RENORM.
  - Else go to PACK.
- RENORM: {hidden,frac}={1,23'b0}; exp=exp+1; go to PACK.
- PACK: the result and both flags are registered at this state's edge, and the FSM returns to IDLE. Priority:
  1. nanIn | (infIn & zeroIn): result=32'h7FC00000; flags 0.
  2. infIn: result={sign,8'hFF,23'b0}; flags 0.
  3. zeroIn: result={sign,31'b0}; flags 0.
  4. exp >= 255 (signed compare): result={sign,8'hFF,23'b0}; overflow=1.
  5. exp <= 0: result={sign,31'b0}; underflow=1. No subnormal output is produced.
  6. Otherwise: result={sign,exp[7:0],frac}.
- Exponent arithmetic: 10-bit signed throughout, so no wrap occurs within the input range.
- Latency: 4 cycles from the capture edge to doneNorm=1 without a rounding carry; 5 cycles with a carry.
- result and flags hold until the next PACK. They are valid whenever doneNorm=1 after at least one completed operation.
- Back-to-back operation: startNorm held high in IDLE starts a new operation on the very edge after the previous PACK.

Decomposition:
- Shared package fp_mul_pkg:
  - EXP_BIAS=127, EXP_INF=255, QNAN=32'h7FC00000;
  - state encoding IDLE/NORM/ROUND/RENORM/PACK;
  - 10-bit exponent type.
- The multiplier and the unpack stage reuse this package.
- One sub-module, fp_round_rne: combinational; inputs {hidden,frac}, guard, sticky; outputs the 24-bit rounded mantissa and the carry.

Test Plan:
- 1.5*1.5: expIn=127, prodIn=48'h900000000000, sign 0 -> result 32'h40100000; latency 4; flags 0.
- Tie to even, LSB 0: expIn=127, prodIn=48'h400000400000 -> 32'h3F800000. Tie with LSB 1: prodIn=48'h400000C00000 -> 32'h3F800002.
- Rounding carry: expIn=127, prodIn=48'h7FFFFFFFFFFF -> 32'h40000000 via RENORM; latency 5.
- Overflow: expIn=254, prodIn=48'h800000000000 -> 32'h7F800000, overflow=1. Underflow: expIn=0, prodIn=48'h400000000000, sign 1 -> 32'h80000000, underflow=1.
- Specials: infIn&zeroIn -> 32'h7FC00000; infIn with sign 1 -> 32'hFF800000; zeroIn with sign 0 -> 32'h00000000.
- Robustness, part 1: startNorm pulsed during NORM is ignored.
- Robustness, part 2: rst asserted in ROUND -> next cycle IDLE, result 0, doneNorm 1, flags 0. Then back-to-back operations with startNorm held high -> two correct results 4 cycles apart.
